// File: rtl/text_pkg.sv
// Shared constants and encodings for the text line buffer:
// the font code of a blank cell, the control bytes, FSM states and byte classes.
package text_pkg;

  localparam logic [5:0] SPACE = 6'o40;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    K_PRINT  = 3'd0,
    K_BS     = 3'd1,
    K_CR     = 3'd2,
    K_FF     = 3'd3,
    K_IGNORE = 3'd4
  } kind_e;

endpackage

// File: rtl/text_line_buffer_if.sv
// Byte-input handshake plus renderer read port and status for the text line buffer.
// The master side is the byte source / renderer; the slave side is the buffer.
interface text_line_buffer_if #(
  parameter int COLW = 3
);
  logic            char_valid;
  logic            char_ready;
  logic [7:0]      char_in;
  logic [COLW-1:0] rd_col;
  logic [5:0]      rd_code;
  logic [COLW-1:0] cursor;
  logic            busy;

  modport master (
    output char_valid,
    output char_in,
    output rd_col,
    input  char_ready,
    input  rd_code,
    input  cursor,
    input  busy
  );

  modport slave (
    input  char_valid,
    input  char_in,
    input  rd_col,
    output char_ready,
    output rd_code,
    output cursor,
    output busy
  );
endinterface

// File: rtl/ascii_font_map.sv
// Combinational byte classifier: maps an ASCII byte to a 6-bit font code and
// a byte class so the line-buffer FSM only has to act on the class.
module ascii_font_map
  import text_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [5:0] code,
  output kind_e      kind
);

  always_comb begin
    code = char_in[5:0];
    kind = K_IGNORE;
    if (char_in[7]) begin
      kind = K_IGNORE;
    end else if (char_in >= 8'h20 && char_in <= 8'h5F) begin
      kind = K_PRINT;
    end else if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      // Folding to uppercase only disturbs the low six bits, so subtract there.
      code = char_in[5:0] - 6'h20;
      kind = K_PRINT;
    end else begin
      unique case (char_in)
        BS:      kind = K_BS;
        CR:      kind = K_CR;
        FF:      kind = K_FF;
        default: kind = K_IGNORE;
      endcase
    end
  end

endmodule

// File: rtl/text_line_buffer.sv
// One-line character store feeding the VGA text renderer: accepts bytes,
// tracks the cursor, runs a one-entry-per-cycle clear, and serves a registered read port.
module text_line_buffer
  import text_pkg::*;
#(
  parameter int NCHARS = 8,
  parameter int COLW   = 3
) (
  input  logic                clk,
  input  logic                ar,
  text_line_buffer_if.slave   bus
);

  localparam logic [COLW-1:0] LAST_COL = COLW'(NCHARS - 1);
  localparam logic [COLW-1:0] ONE_COL  = COLW'(1);

  logic [5:0]      mem_q [NCHARS];
  logic [5:0]      mem_d [NCHARS];
  logic [COLW-1:0] cursor_q, cursor_d;
  logic [COLW-1:0] idx_q, idx_d;
  logic [5:0]      rd_code_q, rd_code_d;
  state_e          state_q, state_d;

  logic [5:0]      map_code;
  kind_e           map_kind;
  logic            xfer;
  logic [COLW-1:0] bs_col;

  ascii_font_map u_map (
    .char_in (bus.char_in),
    .code    (map_code),
    .kind    (map_kind)
  );

  assign bus.char_ready = (state_q == IDLE) & ~ar;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.cursor     = cursor_q;
  assign bus.rd_code    = rd_code_q;

  assign xfer   = bus.char_valid & bus.char_ready;
  assign bs_col = cursor_q - ONE_COL;

  always_comb begin
    mem_d     = mem_q;
    cursor_d  = cursor_q;
    idx_d     = idx_q;
    state_d   = state_q;
    // Read samples the pre-write contents, giving read-before-write on a shared column.
    rd_code_d = mem_q[bus.rd_col];

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          unique case (map_kind)
            K_PRINT: begin
              mem_d[cursor_q] = map_code;
              cursor_d        = cursor_q + ONE_COL;
            end
            K_BS: begin
              if (cursor_q != '0) begin
                cursor_d      = bs_col;
                mem_d[bs_col] = SPACE;
              end
            end
            K_CR: begin
              cursor_d = '0;
            end
            K_FF: begin
              state_d = CLEAR;
              idx_d   = '0;
            end
            default: begin
            end
          endcase
        end
      end
      CLEAR: begin
        mem_d[idx_q] = SPACE;
        idx_d        = idx_q + ONE_COL;
        if (idx_q == LAST_COL) begin
          state_d  = IDLE;
          cursor_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      for (int i = 0; i < NCHARS; i++) begin
        mem_q[i] <= SPACE;
      end
      cursor_q  <= '0;
      idx_q     <= '0;
      rd_code_q <= SPACE;
      state_q   <= IDLE;
    end else begin
      for (int i = 0; i < NCHARS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      cursor_q  <= cursor_d;
      idx_q     <= idx_d;
      rd_code_q <= rd_code_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: doc/text_line_buffer.md
# text_line_buffer

Character line buffer directly upstream of the VGA text renderer. It accepts ASCII bytes over a valid/ready handshake, maps them to 6-bit font codes, and stores them in an NCHARS-entry line. It also maintains a cursor and handles backspace, carriage return and clear. The renderer reads one code per character cell through a registered read port whose code feeds the font ROM address.

## Interface
- NCHARS, 8: characters per line; power of two, 2..64
- COLW, 3: column index width, equal to log2(NCHARS)
- clk  in  1: pixel-domain clock (25 MHz)
- ar  in  1: reset, synchronous, active-high
- char_valid  in  1: char_in holds a byte to consume
- char_ready  out  1: block can accept a byte this cycle
- char_in  in  8: ASCII byte
- rd_col  in  COLW: column requested by renderer
- rd_code  out  6: font code of rd_col, registered
- cursor  out  COLW: next write column
- busy  out  1: clear sequence in progress

## Operation
- Reset (ar=1 at a clk edge):
  - every entry = SPACE (6'o40)
  - cursor=0, state=IDLE, rd_code=6'o40, busy=0, char_ready=0
- First cycle after reset: char_ready=1.
- Transfer occurs on a clk edge with char_valid & char_ready.
- char_ready = (state==IDLE) & ~ar.
- Byte classes:
  - 0x20–0x5F printable: code=char_in[5:0]. Store at cursor. Cursor=cursor+1, wrapping NCHARS-1→0.
  - 0x61–0x7A lowercase: folded to uppercase (char_in−0x20), then treated as printable.
  - 0x08 backspace:
    - cursor>0: cursor−1 and that entry=SPACE.
    - cursor==0: no change.
  - 0x0D carriage return: cursor=0. Contents unchanged.
  - 0x0C form feed: enter CLEAR.
  - All other bytes: consumed, no effect.
- FSM:
  - IDLE: transfer of 0x0C → CLEAR, idx=0.
  - CLEAR: writes SPACE to entry idx, idx+1 per cycle. After idx==NCHARS-1 is written → IDLE with cursor=0.
  - In CLEAR: busy=1, char_ready=0.
- Width rules:
  - cursor and idx are COLW bits and wrap modulo NCHARS.
  - char_in[7]=1 is always ignored.
- Reset mid-CLEAR aborts the sequence. The reset state above applies on that edge.

## Timing
- Read latency is 1 cycle: rd_code at edge k+1 = entry[rd_col sampled at edge k].
- Read-before-write: reading the column being written at edge k returns the old code after k+1 and the new code from k+2.
- A write at edge k is visible to a read issued at edge k+1.
- Throughput:
  - IDLE: one byte per cycle.
  - A form feed costs exactly NCHARS cycles of char_ready=0, starting the cycle after acceptance.
- A clear entry written at cycle j reads SPACE from j+1. Uncleared entries read their old codes.
- cursor updates on the transfer edge and is registered. Backspace and its SPACE write complete in the same edge.

## Structure
- Shared package text_pkg holds:
  - SPACE=6'o40
  - ASCII constants BS=8'h08, FF=8'h0C, CR=8'h0D
  - state encoding IDLE/CLEAR
- One combinational sub-module, ascii_font_map:
  - char_in → {code[5:0], kind}, where kind ∈ PRINT/BS/CR/FF/IGNORE.
  - Keeps classification out of the FSM.
- Storage is a flat register array; no RAM macro.

## Test plan
- Reset, then read rd_col 0..7 → rd_code=6'o40 each, one cycle late; cursor=0, char_ready=1.
- Send "2+3" (0x32,0x2B,0x33) back-to-back → entries 0..2 = 6'o62, 6'o53, 6'o63; cursor=3.
- Send 9 printable bytes 'A'..'I' from cursor 0 → entry 0='I' (6'o11), entries 1..7='B'..'H'; cursor=1.
- Backspace at cursor=0 → no change. After "ab", backspace → entry1=6'o40, entry0=6'o01, cursor=1.
- Form feed with char_valid held high → char_ready low for exactly 8 cycles, busy high, all entries 6'o40, cursor=0, next byte lands in entry 0.
- Assert ar at CLEAR idx=3 → next cycle all entries SPACE, busy=0, char_ready=0, then 1 after release. Bytes 0x07 and 0x80 → consumed, no state change.
